eth_frame_log_packer: RTL
=========================

Name: eth_frame_log_packer

Overview:
- Sits directly downstream of the frame-detector loop extractor, in the log clock domain.
- Pops one control record per captured frame from the control FIFO and the matching data words from the frame FIFO.
- Emits one AXI-Stream log record per frame: a fixed 128-bit header followed by the frame payload words, with tlast on the final word.
- The output feeds the log DMA/stream mux.

Parameters:
- C_NUM_SCRIPTS, 4: number of detector scripts; match bits used = C_NUM_SCRIPTS, 1..8.
- C_AXIS_LOG_WIDTH, 64: data width of frame input and log output; legal values 32, 64, 128.
- C_MAX_FRAME_BYTES, 2048: cap on payload bytes consumed per record; must be a multiple of C_AXIS_LOG_WIDTH/8.

Ports:
- clk  in  1  log clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_ctl_tdata  in  122  {match[121:114], fcs_incorrect[113], frame_bad[112], size[111:96], number[95:64], timestamp[63:0]}.
- s_axis_ctl_tvalid  in  1  control record valid.
- s_axis_ctl_tready  out  1  control record pop.
- s_axis_frame_tdata  in  C_AXIS_LOG_WIDTH  payload word; byte 0 in bits [7:0].
- s_axis_frame_tvalid  in  1  payload word valid.
- s_axis_frame_tready  out  1  payload word pop.
- m_axis_log_tdata  out  C_AXIS_LOG_WIDTH  log record word.
- m_axis_log_tlast  out  1  last word of record.
- m_axis_log_tvalid  out  1  output valid.
- m_axis_log_tready  in  1  output ready.
- record_count  out  32  records emitted, wraps.
- drop_count  out  32  records discarded; see Optional Feature.

Behaviour:
- Reset (async assert, sync release), all outputs 0:
  - state=ST_IDLE; ctl/frame tready=0; m_axis_log_tvalid/tlast/tdata=0; both counters=0.
- Header (128 bits, sent LSW first in 128/W words):
  - H[63:0] = timestamp.
  - H[95:64] = number.
  - H[111:96] = size.
  - H[112] = frame_bad; H[113] = fcs_incorrect.
  - H[119:114] = 0.
  - H[127:120] = match, zero-extended above C_NUM_SCRIPTS.
- Payload word count:
  - B = C_AXIS_LOG_WIDTH/8.
  - N = ceil(min(size, C_MAX_FRAME_BYTES)/B).
  - Computed in 17 bits; no overflow at size=16'hFFFF.
- ST_IDLE:
  - When ctl_tvalid: pulse ctl_tready for one cycle, latch the record, compute N, go to ST_HDR.
  - Record latched at edge k; first header word tvalid at edge k+1.
- ST_HDR:
  - Present header words in order.
  - Advance on m_axis_log_tvalid & m_axis_log_tready.
  - After the last header word: if N=0 go to ST_IDLE; else go to ST_DATA.
  - When N=0, tlast is set on the last header word.
- ST_DATA:
  - frame_tready = ~m_axis_log_tvalid | m_axis_log_tready (output register empty or draining).
  - Each frame handshake loads the word into the output register and decrements the remaining count.
  - tlast is set on the N-th word.
  - record_count increments on the tlast handshake; return to ST_IDLE.
- ST_DRAIN:
  - Only used with the optional feature.
  - frame_tready=1 until N words are popped; no output; then return to ST_IDLE.
- Output handshake:
  - Standard AXIS: tdata/tlast stable while tvalid & ~tready.
  - No bubbles when input and output are both ready: one word per cycle sustained.
- A new ctl record is accepted only in ST_IDLE. Back-to-back records cost exactly one idle cycle between tlast and the next header word.
- Frame words arriving while in ST_IDLE/ST_HDR are not consumed: frame_tready=0.
- Simultaneous output-ready drop and frame_tvalid: word held, none lost, none duplicated.
- rst mid-record: everything returns to reset values immediately. Partial records are not completed. Upstream FIFOs are reset by the same system reset.

Optional Feature:
- Macro ETH_LOG_PACK_DROP_UNMATCHED_EN.
- Defined:
  - A record whose match bits are all zero goes ST_IDLE -> ST_DRAIN instead of ST_HDR.
  - Its N payload words are popped and discarded; nothing is emitted.
  - drop_count increments once when the drain completes; if N=0 it increments in the cycle the record is latched.
- Undefined:
  - All records are emitted.
  - ST_DRAIN is not synthesized.
  - drop_count is tied to 0.

Test Plan:
- W=64; ctl {match=4'b0010, size=12, number=7, ts=64'h1122334455667788}; two frame words -> 4 output words: 64'h1122334455667788; then {8'h02, 6'd0, 2'b00, 16'd12, 32'd7}; then data0, data1 with tlast; record_count=1.
- size=0 -> exactly 2 header words, tlast on the second; frame_tready never asserted.
- m_axis_log_tready toggled 1/0 every cycle during a 9-byte frame (N=2) -> output sequence identical to the ready=1 run; no word dropped or duplicated.
- Three back-to-back records, sizes 8/16/1, ready=1 -> 3+4+3 words; exactly one idle cycle between records; record_count=3.
- size=16'hFFFF, C_MAX_FRAME_BYTES=2048 -> 256 payload words consumed; header still reports size=16'hFFFF.
- With ETH_LOG_PACK_DROP_UNMATCHED_EN: record match=0, size=20, then a matched record -> 3 words drained silently, drop_count=1; second record emitted intact. Without the macro, both records are emitted and drop_count=0.

Source files
------------

// File: rtl/eth_frame_log_packer.sv
// eth_frame_log_packer
//   Builds one AXI-Stream log record per captured frame: pops a control
//   record, emits a 128-bit header (LSW first, 128/W words) and then the
//   frame payload words from the frame FIFO, with tlast on the final word.
//
//   Optional feature macro: ETH_LOG_PACK_DROP_UNMATCHED_EN
//     defined   -> records whose (masked) match bits are all zero are
//                  drained from the frame FIFO silently and counted in
//                  drop_count.
//     undefined -> every record is emitted, drop_count is tied to 0.
//
// Ports
//   clk, rst                 log clock, asynchronous active-high reset
//   s_axis_ctl_*             control record input (122 bits)
//   s_axis_frame_*           payload word input (C_AXIS_LOG_WIDTH bits)
//   m_axis_log_*             log record output stream
//   record_count             records emitted (wraps)
//   drop_count               records discarded (wraps)
module eth_frame_log_packer #(
    parameter int unsigned C_NUM_SCRIPTS     = 4,
    parameter int unsigned C_AXIS_LOG_WIDTH  = 64,
    parameter int unsigned C_MAX_FRAME_BYTES = 2048
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [121:0]                  s_axis_ctl_tdata,
    input  logic                          s_axis_ctl_tvalid,
    output logic                          s_axis_ctl_tready,
    input  logic [C_AXIS_LOG_WIDTH-1:0]   s_axis_frame_tdata,
    input  logic                          s_axis_frame_tvalid,
    output logic                          s_axis_frame_tready,
    output logic [C_AXIS_LOG_WIDTH-1:0]   m_axis_log_tdata,
    output logic                          m_axis_log_tlast,
    output logic                          m_axis_log_tvalid,
    input  logic                          m_axis_log_tready,
    output logic [31:0]                   record_count,
    output logic [31:0]                   drop_count
);

    localparam int unsigned BYTES = C_AXIS_LOG_WIDTH / 8;
    localparam int unsigned BSH   = $clog2(BYTES);
    localparam int unsigned HW    = 128 / C_AXIS_LOG_WIDTH;
    localparam logic [16:0] MAXB  = 17'(C_MAX_FRAME_BYTES);
    localparam logic [7:0]  MATCH_MASK = 8'((32'd1 << C_NUM_SCRIPTS) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
`ifdef ETH_LOG_PACK_DROP_UNMATCHED_EN
        , ST_DRAIN
`endif
    } state_t;

    state_t                        state_q;
    logic [127:0]                  hdr_q;       // header words not yet presented, LSW aligned
    logic [1:0]                    hdr_left_q;  // header words remaining after the one on the output
    logic [16:0]                   rem_q;       // payload words still to pop
    logic [C_AXIS_LOG_WIDTH-1:0]   tdata_q;
    logic                          tvalid_q;
    logic                          tlast_q;
    logic [31:0]                   rec_cnt_q;

    logic [7:0]                    match_d;
    logic [127:0]                  hdr_d;
    logic [16:0]                   size_d;
    logic [16:0]                   capped_d;
    logic [16:0]                   n_d;
    logic                          out_fire;
    logic                          frame_fire;

    // Header and payload word count derived straight from the FIFO head,
    // so the first header word can be loaded in the same edge as the pop.
    always_comb begin
        match_d  = s_axis_ctl_tdata[121:114] & MATCH_MASK;
        hdr_d    = {match_d, 6'd0, s_axis_ctl_tdata[113:0]};
        size_d   = {1'b0, s_axis_ctl_tdata[111:96]};
        capped_d = (size_d > MAXB) ? MAXB : size_d;
        n_d      = 17'((capped_d + 17'(BYTES - 1)) >> BSH);
    end

    always_comb begin
        s_axis_ctl_tready   = (state_q == ST_IDLE) && s_axis_ctl_tvalid;
        s_axis_frame_tready = 1'b0;
        case (state_q)
            ST_DATA:  s_axis_frame_tready = (rem_q != '0) && (!tvalid_q || m_axis_log_tready);
`ifdef ETH_LOG_PACK_DROP_UNMATCHED_EN
            ST_DRAIN: s_axis_frame_tready = (rem_q != '0);
`endif
            default:  s_axis_frame_tready = 1'b0;
        endcase
        out_fire   = tvalid_q && m_axis_log_tready;
        frame_fire = s_axis_frame_tready && s_axis_frame_tvalid;
    end

`ifdef ETH_LOG_PACK_DROP_UNMATCHED_EN
    logic [31:0] drop_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            hdr_left_q <= '0;
            rem_q      <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            rec_cnt_q  <= '0;
`ifdef ETH_LOG_PACK_DROP_UNMATCHED_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_ctl_tvalid) begin
                        rem_q      <= n_d;
                        hdr_q      <= hdr_d >> C_AXIS_LOG_WIDTH;
                        hdr_left_q <= 2'(HW - 1);
`ifdef ETH_LOG_PACK_DROP_UNMATCHED_EN
                        if (match_d == '0) begin
                            if (n_d == '0) begin
                                drop_cnt_q <= drop_cnt_q + 32'd1;
                            end else begin
                                state_q <= ST_DRAIN;
                            end
                        end else
`endif
                        begin
                            tdata_q  <= hdr_d[C_AXIS_LOG_WIDTH-1:0];
                            tvalid_q <= 1'b1;
                            tlast_q  <= (HW == 1) && (n_d == '0);
                            state_q  <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (out_fire) begin
                        if (hdr_left_q == '0) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            if (rem_q == '0) begin
                                rec_cnt_q <= rec_cnt_q + 32'd1;
                                state_q   <= ST_IDLE;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end else begin
                            tdata_q    <= hdr_q[C_AXIS_LOG_WIDTH-1:0];
                            hdr_q      <= hdr_q >> C_AXIS_LOG_WIDTH;
                            hdr_left_q <= hdr_left_q - 2'd1;
                            tlast_q    <= (hdr_left_q == 2'd1) && (rem_q == '0);
                        end
                    end
                end
                ST_DATA: begin
                    // A pop always refills the output register; tlast_q implies
                    // rem_q==0, so a pop never coincides with the final drain.
                    if (frame_fire) begin
                        tdata_q  <= s_axis_frame_tdata;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (rem_q == 17'd1);
                        rem_q    <= rem_q - 17'd1;
                    end else if (out_fire) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        if (tlast_q) begin
                            rec_cnt_q <= rec_cnt_q + 32'd1;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
`ifdef ETH_LOG_PACK_DROP_UNMATCHED_EN
                ST_DRAIN: begin
                    if (frame_fire) begin
                        rem_q <= rem_q - 17'd1;
                        if (rem_q == 17'd1) begin
                            drop_cnt_q <= drop_cnt_q + 32'd1;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_log_tdata  = tdata_q;
    assign m_axis_log_tvalid = tvalid_q;
    assign m_axis_log_tlast  = tlast_q;
    assign record_count      = rec_cnt_q;

endmodule
